// File: rtl/r5p_bus_arb_pkg.sv
// r5p_bus_arb_pkg: grant FSM states, response owners and round-robin encoding for the r5p bus arbiter
package r5p_bus_arb_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_LOCK_IF, ARB_LOCK_LS} arb_state_t;
  typedef enum logic [1:0] {RSP_NONE, RSP_IF, RSP_LS} rsp_t;
  localparam logic LAST_IF = 1'b0;
  localparam logic LAST_LS = 1'b1;
endpackage

// File: rtl/r5p_bus_arb_if.sv
// r5p_bus_arb_if: one request/acknowledge memory bus, master drives the request, slave answers
interface r5p_bus_arb_if #(
  parameter int AW = 16,
  parameter int DW = 32,
  parameter int SW = DW/8
);
  logic          req;
  logic          wen;
  logic [AW-1:0] adr;
  logic [SW-1:0] sel;
  logic [DW-1:0] wdt;
  logic [DW-1:0] rdt;
  logic          ack;
  modport master (output req, wen, adr, sel, wdt, input rdt, ack);
  modport slave  (input req, wen, adr, sel, wdt, output rdt, ack);
endinterface

// File: rtl/r5p_arb2.sv
// r5p_arb2: 2-way combinational grant, LS priority or round-robin on ties when R5P_BUS_ARB_RR_EN is defined
module r5p_arb2
  import r5p_bus_arb_pkg::*;
(
  input  logic req_if,
  input  logic req_ls,
`ifdef R5P_BUS_ARB_RR_EN
  input  logic last,
`endif
  output logic gnt_if,
  output logic gnt_ls
);
`ifdef R5P_BUS_ARB_RR_EN
  assign gnt_ls = req_ls & (~req_if | (last == LAST_IF));
`else
  assign gnt_ls = req_ls;
`endif
  assign gnt_if = req_if & ~gnt_ls;
endmodule

// File: rtl/r5p_bus_arb.sv
// r5p_bus_arb: shares one memory between IF and LS buses with stall lock and response routing; R5P_BUS_ARB_RR_EN enables round-robin
module r5p_bus_arb
  import r5p_bus_arb_pkg::*;
#(
  parameter int AW = 16,
  parameter int DW = 32,
  parameter int SW = DW/8
)(
  input  logic           clk,
  input  logic           rst,
  r5p_bus_arb_if.slave   if_bus,
  r5p_bus_arb_if.slave   ls_bus,
  r5p_bus_arb_if.master  mem_bus
);
  arb_state_t st;
  rsp_t       rsp;
  logic       arb_if, arb_ls, gnt_if, gnt_ls, xfer;
`ifdef R5P_BUS_ARB_RR_EN
  logic       last;
`endif
  r5p_arb2 u_arb (
    .req_if(if_bus.req),
    .req_ls(ls_bus.req),
`ifdef R5P_BUS_ARB_RR_EN
    .last  (last),
`endif
    .gnt_if(arb_if),
    .gnt_ls(arb_ls)
  );
  // grants are masked by rst so nothing leaks out while reset is held
  assign gnt_if = ~rst & (st == ARB_LOCK_IF ? if_bus.req : st == ARB_LOCK_LS ? 1'b0 : arb_if);
  assign gnt_ls = ~rst & (st == ARB_LOCK_LS ? ls_bus.req : st == ARB_LOCK_IF ? 1'b0 : arb_ls);
  assign xfer   = mem_bus.req & mem_bus.ack;
  assign mem_bus.req = gnt_if | gnt_ls;
  assign mem_bus.wen = gnt_ls & ls_bus.wen;
  assign mem_bus.adr = gnt_ls ? ls_bus.adr : gnt_if ? if_bus.adr : '0;
  assign mem_bus.sel = gnt_ls ? ls_bus.sel : {SW{gnt_if}};
  assign mem_bus.wdt = gnt_ls ? ls_bus.wdt : '0;
  assign if_bus.ack  = gnt_if & mem_bus.ack;
  assign ls_bus.ack  = gnt_ls & mem_bus.ack;
  assign if_bus.rdt  = rsp == RSP_IF ? mem_bus.rdt : '0;
  assign ls_bus.rdt  = rsp == RSP_LS ? mem_bus.rdt : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st  <= ARB_IDLE;
      rsp <= RSP_NONE;
`ifdef R5P_BUS_ARB_RR_EN
      last <= LAST_IF;
`endif
    end else begin
      st  <= gnt_ls & ~mem_bus.ack ? ARB_LOCK_LS : gnt_if & ~mem_bus.ack ? ARB_LOCK_IF : ARB_IDLE;
      rsp <= ~xfer | mem_bus.wen ? RSP_NONE : gnt_ls ? RSP_LS : RSP_IF;
`ifdef R5P_BUS_ARB_RR_EN
      if (xfer) last <= gnt_ls;
`endif
    end
endmodule

// File: tb/tb_r5p_bus_arb.sv
// tb_r5p_bus_arb: randomized scoreboard bench for r5p_bus_arb (honours R5P_BUS_ARB_RR_EN)
module tb_r5p_bus_arb;
  import r5p_bus_arb_pkg::*;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SW = 4;
  typedef struct packed {
    logic          wen;
    logic [AW-1:0] adr;
    logic [SW-1:0] sel;
    logic [DW-1:0] wdt;
  } txn_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  r5p_bus_arb_if #(AW, DW, SW) if_bus ();
  r5p_bus_arb_if #(AW, DW, SW) ls_bus ();
  r5p_bus_arb_if #(AW, DW, SW) mem_bus ();

  r5p_bus_arb #(.AW(AW), .DW(DW), .SW(SW)) dut (
    .clk    (clk),
    .rst    (rst),
    .if_bus (if_bus),
    .ls_bus (ls_bus),
    .mem_bus(mem_bus)
  );

  int checks = 0;
  int failures = 0;
  txn_t q_if[$];
  txn_t q_ls[$];
  int wins[$];
  logic [DW-1:0] mem [64];
  logic [DW-1:0] gold [64];
  logic if_acked = 1'b0;
  logic ls_acked = 1'b0;
  int hold = 0;
  int last = 0;
  int pend_own = 0;
  logic [DW-1:0] pend_dat = '0;

  function automatic int idx(input logic [AW-1:0] a);
    return int'(a[7:2]);
  endfunction

  function automatic logic [DW-1:0] init_word(input int i);
    return i == 4 ? 32'h0000_0013 : 32'hA500_0000 | (i * 32'h0101);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // memory slave: read data one cycle after the transfer, noise otherwise
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
      mem_bus.rdt <= $urandom;
    end else if (mem_bus.req && mem_bus.ack) begin
      if (mem_bus.wen)
        for (int b = 0; b < SW; b++)
          if (mem_bus.sel[b]) mem[idx(mem_bus.adr)][8*b +: 8] <= mem_bus.wdt[8*b +: 8];
      mem_bus.rdt <= mem_bus.wen ? DW'($urandom) : mem[idx(mem_bus.adr)];
    end else begin
      mem_bus.rdt <= $urandom;
    end
  end

  // reference model and monitor
  always @(negedge clk) begin
    logic eg_if, eg_ls, rr_if;
    txn_t e, t;
    chk("if_rdt", 64'(if_bus.rdt), 64'((!rst && pend_own == 1) ? pend_dat : '0));
    chk("ls_rdt", 64'(ls_bus.rdt), 64'((!rst && pend_own == 2) ? pend_dat : '0));
`ifdef R5P_BUS_ARB_RR_EN
    rr_if = (last == 1);
`else
    rr_if = 1'b0;
`endif
    eg_if = 1'b0;
    eg_ls = 1'b0;
    if (rst) begin
      hold = 0;
      pend_own = 0;
`ifdef R5P_BUS_ARB_RR_EN
      last = 0;
`endif
      for (int i = 0; i < 64; i++) gold[i] = init_word(i);
    end else if (hold == 1) eg_if = if_bus.req;
    else if (hold == 2) eg_ls = ls_bus.req;
    else if (if_bus.req && ls_bus.req) begin
      eg_if = rr_if;
      eg_ls = !rr_if;
    end else begin
      eg_if = if_bus.req;
      eg_ls = ls_bus.req;
    end
    chk("mem_req", 64'(mem_bus.req), 64'(eg_if | eg_ls));
    chk("if_ack", 64'(if_bus.ack), 64'(eg_if & mem_bus.ack));
    chk("ls_ack", 64'(ls_bus.ack), 64'(eg_ls & mem_bus.ack));
    e = '0;
    if (eg_ls && q_ls.size() > 0) e = q_ls[0];
    else if (eg_if && q_if.size() > 0) e = q_if[0];
    chk("mem_wen", 64'(mem_bus.wen), 64'(e.wen));
    chk("mem_adr", 64'(mem_bus.adr), 64'(e.adr));
    chk("mem_sel", 64'(mem_bus.sel), 64'(e.sel));
    chk("mem_wdt", 64'(mem_bus.wdt), 64'(e.wdt));
    if_acked = eg_if & mem_bus.ack;
    ls_acked = eg_ls & mem_bus.ack;
    pend_own = 0;
    if ((eg_if || eg_ls) && mem_bus.ack) begin
      t = eg_ls ? q_ls.pop_front() : q_if.pop_front();
      wins.push_back(eg_ls ? 2 : 1);
      if (t.wen) begin
        for (int b = 0; b < SW; b++)
          if (t.sel[b]) gold[idx(t.adr)][8*b +: 8] = t.wdt[8*b +: 8];
      end else begin
        pend_own = eg_ls ? 2 : 1;
        pend_dat = gold[idx(t.adr)];
      end
`ifdef R5P_BUS_ARB_RR_EN
      last = eg_ls ? 1 : 0;
`endif
      hold = 0;
    end else begin
      hold = eg_ls ? 2 : eg_if ? 1 : 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (if_acked) if_bus.req = 1'b0;
    if (ls_acked) ls_bus.req = 1'b0;
  endtask

  task automatic start_if(input logic [AW-1:0] a);
    if_bus.req = 1'b1;
    if_bus.adr = a;
    if_bus.wen = 1'($urandom);
    if_bus.sel = SW'($urandom);
    if_bus.wdt = $urandom;
    q_if.push_back(txn_t'{wen: 1'b0, adr: a, sel: {SW{1'b1}}, wdt: '0});
  endtask

  task automatic start_ls(input logic w, input logic [AW-1:0] a, input logic [SW-1:0] s, input logic [DW-1:0] d);
    ls_bus.req = 1'b1;
    ls_bus.wen = w;
    ls_bus.adr = a;
    ls_bus.sel = s;
    ls_bus.wdt = d;
    q_ls.push_back(txn_t'{wen: w, adr: a, sel: s, wdt: d});
  endtask

  task automatic drain();
    int n = 0;
    mem_bus.ack = 1'b1;
    while ((if_bus.req || ls_bus.req) && n < 50) begin
      tick();
      n++;
    end
    chk("drain_timeout", 64'(n < 50), 64'(1));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    if_bus.req = 1'b0; if_bus.wen = 1'b0; if_bus.adr = '0; if_bus.sel = '0; if_bus.wdt = '0;
    ls_bus.req = 1'b0; ls_bus.wen = 1'b0; ls_bus.adr = '0; ls_bus.sel = '0; ls_bus.wdt = '0;
    mem_bus.ack = 1'b1;
    start_if(16'h0010);
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("iso_if_ack", 64'(if_bus.ack), 64'(1));
    tick();
    @(negedge clk);
    chk("iso_if_rdt", 64'(if_bus.rdt), 64'h13);
    chk("iso_ls_rdt", 64'(ls_bus.rdt), 64'(0));
    tick();
    start_if(16'h0020);
    start_ls(1'b1, 16'h1000, 4'b0001, 32'h41);
    @(negedge clk);
    chk("sim_ls_ack", 64'(ls_bus.ack), 64'(1));
    chk("sim_wen", 64'(mem_bus.wen), 64'(1));
    tick();
    @(negedge clk);
    chk("sim_if_ack", 64'(if_bus.ack), 64'(1));
    tick();
    @(negedge clk);
    chk("sim_if_rdt", 64'(if_bus.rdt), 64'(init_word(8)));
    tick();
    mem_bus.ack = 1'b0;
    start_ls(1'b0, 16'h0100, 4'hF, 32'h0);
    start_if(16'h0030);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_adr", 64'(mem_bus.adr), 64'h0100);
      chk("stall_if_ack", 64'(if_bus.ack), 64'(0));
      tick();
    end
    mem_bus.ack = 1'b1;
    @(negedge clk);
    chk("stall_ls_ack", 64'(ls_bus.ack), 64'(1));
    tick();
    @(negedge clk);
    chk("stall_if_next", 64'(if_bus.ack), 64'(1));
    tick();
    start_ls(1'b1, 16'h0004, 4'b1100, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("wr_ls_ack", 64'(ls_bus.ack), 64'(1));
    tick();
    @(negedge clk);
    chk("wr_if_rdt", 64'(if_bus.rdt), 64'(0));
    chk("wr_ls_rdt", 64'(ls_bus.rdt), 64'(0));
    tick();
    start_if(16'h0008);
    @(negedge clk);
    chk("rmr_ack", 64'(if_bus.ack), 64'(1));
    tick();
    rst = 1'b1;
    start_if(16'h000C);
    @(negedge clk);
    chk("rmr_rdt", 64'(if_bus.rdt), 64'(0));
    chk("rmr_no_ack", 64'(if_bus.ack), 64'(0));
    chk("rmr_no_req", 64'(mem_bus.req), 64'(0));
    repeat (2) tick();
    rst = 1'b0;
    drain();
    tick();
    wins.delete();
    start_if(16'h0040);
    start_ls(1'b0, 16'h0044, 4'hF, 32'h0);
    repeat (6) begin
      tick();
      if (!if_bus.req) start_if(AW'($urandom));
      if (!ls_bus.req) start_ls(1'($urandom), AW'($urandom), SW'($urandom), DW'($urandom));
    end
    chk("fair_count", 64'(wins.size() >= 6), 64'(1));
    for (int k = 0; k < 6 && k < wins.size(); k++)
`ifdef R5P_BUS_ARB_RR_EN
      chk("fair_order", 64'(wins[k]), 64'(k % 2 == 0 ? 2 : 1));
`else
      chk("prio_order", 64'(wins[k]), 64'(2));
`endif
    drain();
    repeat (2000) begin
      tick();
      mem_bus.ack = ($urandom % 4) != 0;
      if (!if_bus.req && ($urandom % 2)) start_if(AW'($urandom));
      if (!ls_bus.req && ($urandom % 2)) start_ls(1'($urandom), AW'($urandom), SW'($urandom), DW'($urandom));
    end
    drain();
    tick();
    chk("q_if_empty", 64'(q_if.size()), 64'(0));
    chk("q_ls_empty", 64'(q_ls.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/r5p_bus_arb.md
# r5p_bus_arb

Two-master bus arbiter that lets the r5p core's instruction-fetch (IF) bus and load/store (LS) bus share one single-ported synchronous memory. It sits between `r5p_core` and one `mem` instance. It selects one master per memory cycle and holds a stalled grant until the memory accepts it. It also tracks which master owns the read data returned one cycle after each transfer.

## Interface
Parameters:
- `AW`, 16, shared memory byte address width (IF and LS addresses both AW bits).
- `DW`, 32, data width (IF data and LS data).
- `SW`, DW/8, byte select width.

Ports:
- `clk`  in  1  clock. One clock domain.
- `rst`  in  1  reset. Asynchronous, active-high.
- `if_req`  in  1  IF request.
- `if_adr`  in  AW  IF address.
- `if_rdt`  out  DW  IF read data.
- `if_ack`  out  1  IF acknowledge.
- `ls_req`  in  1  LS request.
- `ls_wen`  in  1  LS write enable.
- `ls_adr`  in  AW  LS address.
- `ls_sel`  in  SW  LS byte select.
- `ls_wdt`  in  DW  LS write data.
- `ls_rdt`  out  DW  LS read data.
- `ls_ack`  out  1  LS acknowledge.
- `mem_req`  out  1  memory request.
- `mem_wen`  out  1  memory write enable.
- `mem_adr`  out  AW  memory address.
- `mem_sel`  out  SW  memory byte select.
- `mem_wdt`  out  DW  memory write data.
- `mem_rdt`  in  DW  memory read data; valid the cycle after a read transfer.
- `mem_ack`  in  1  memory acknowledge; may be low to stall.

## Operation
- **Transfer rule:** a transfer occurs on a cycle with `x_req & x_ack` high. Masters hold the request and its payload stable until acknowledged.
- **Grant FSM:** states `IDLE`, `LOCK_IF`, `LOCK_LS`.
  - `IDLE`: arbitrate among the current requests using the policy below. The winner is granted in the same cycle.
  - If the winner's transfer does not complete (`mem_ack` low), go to `LOCK_<winner>`.
  - `LOCK_x`: the grant stays with x regardless of other requests. Return to `IDLE` on x's transfer.
  - If x drops `x_req` while locked (a protocol violation), return to `IDLE` and assert nothing.
- **Forwarding:**
  - `mem_req` = granted master's req.
  - The address, sel, wen and wdt muxes follow the grant.
  - IF is forced to `mem_wen`=0 and `mem_sel`='1.
  - `mem_wdt`='0 when IF is granted.
  - Only the granted master sees `mem_ack`. The other master's ack is 0.
- **Response owner register `rsp`** (NONE/IF/LS):
  - Loads the granted master on a read transfer.
  - Loads NONE on a write transfer or a cycle with no transfer.
  - `if_rdt` = `mem_rdt` when `rsp`==IF, else '0. `ls_rdt` uses the same rule with LS.
- **Default policy:** fixed priority, LS over IF.
- **Simultaneous events:** a transfer completing while the other master requests means the other master can win in the very next cycle. Back-to-back transfers by different masters are allowed with no idle cycle.

## Timing
- Reset values: FSM=`IDLE`, `rsp`=NONE.
  - With no requests, all outputs are 0: `mem_req`, `mem_wen`, `mem_adr`, `mem_sel`, `mem_wdt`, both acks, both rdt.
  - Outputs stay 0 throughout reset.
- Request path is combinational, zero latency: req → mem_req and mem_ack → x_ack in the same cycle.
- Read data reaches the owner exactly 1 cycle after its transfer. This is the same latency as a direct memory connection.
- Reset asserted mid-operation: FSM, `rsp` and the RR pointer return to reset values immediately. A pending response is discarded.
- Throughput: 1 transfer/cycle when `mem_ack` is high.

## Configuration
- `R5P_BUS_ARB_RR_EN` defined:
  - In `IDLE` with both masters requesting, grant the master that did not win the most recent transfer.
  - A 1-bit `last` register is set on each transfer and reset to IF, so LS wins the first tie.
- `R5P_BUS_ARB_RR_EN` undefined:
  - Fixed LS priority; no `last` register.
  - IF can starve under continuous LS traffic. This is accepted.

## Structure
- Package `r5p_bus_arb_pkg`:
  - `typedef enum logic [1:0] {ARB_IDLE, ARB_LOCK_IF, ARB_LOCK_LS}`.
  - `typedef enum logic [1:0] {RSP_NONE, RSP_IF, RSP_LS}`.
- Sub-module `r5p_arb2`: a 2-way combinational grant with an optional RR `last` input. The FSM, `rsp` register and muxes live in `r5p_bus_arb`.

## Test plan
- **Isolated IF read:** `if_req`=1, `if_adr`=0x0010, `mem_ack`=1, memory word 0x00000013 → `if_ack`=1 same cycle; `if_rdt`=0x00000013 next cycle; `ls_rdt`=0.
- **Simultaneous requests, fixed priority:** IF read 0x0020 and LS write 0x1000 (`sel`=4'b0001, `wdt`=0x41) → cycle 0 `ls_ack`=1, `mem_wen`=1; cycle 1 `if_ack`=1; `if_rdt` valid cycle 2.
- **Stall lock:** LS read 0x0100 granted with `mem_ack`=0 for 3 cycles while IF requests → `mem_adr` stays 0x0100 and `if_ack`=0 throughout; IF transfers the cycle after `ls_ack`.
- **RR fairness (`R5P_BUS_ARB_RR_EN`):** both masters request continuously for 6 cycles, `mem_ack`=1 → grants alternate LS, IF, LS, IF, LS, IF.
- **Write produces no response:** LS write then idle → `rsp`=NONE and both rdt = 0 in the following cycle.
- **Reset mid-read:** IF read transfers and `rst` asserts the next cycle → `if_rdt`=0, FSM `IDLE`, no ack while reset is held.
